// File: rtl/pattern_scheduler_if.sv
// Pixel-side bundle between the timing block / pattern generators and the
// pattern scheduler. The master drives raster position, sources and buttons;
// the slave (scheduler) returns the selected colour and status.
interface pattern_scheduler_if #(
   parameter int N_PAT = 4,
   parameter int SEL_W = 2
);
   logic [31:0]          X;
   logic [31:0]          Y;
   logic                 enable;
   logic [3*N_PAT-1:0]   pat_rgb;
   logic                 btn_next;
   logic                 btn_hold;
   logic                 r;
   logic                 g;
   logic                 b;
   logic [SEL_W-1:0]     pat_sel;
   logic                 frame_end;
   logic                 holding;

   modport master (
      output X, Y, enable, pat_rgb, btn_next, btn_hold,
      input  r, g, b, pat_sel, frame_end, holding
   );

   modport slave (
      input  X, Y, enable, pat_rgb, btn_next, btn_hold,
      output r, g, b, pat_sel, frame_end, holding
   );
endinterface

// File: rtl/pattern_scheduler.sv
// Frame-synchronous pattern scheduler: picks one of N_PAT RGB sources per
// frame, switching only on the last visible pixel. Auto-advances every
// FRAMES_PER_PAT frames, or on a btn_next rising edge; btn_hold freezes auto.
module pattern_scheduler #(
   parameter int H              = 640,
   parameter int V              = 480,
   parameter int N_PAT          = 4,
   parameter int FRAMES_PER_PAT = 60,
   parameter int SEL_W          = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   pattern_scheduler_if.slave bus
);
   localparam int                CNT_W    = $clog2(FRAMES_PER_PAT) + 1;
   localparam logic [31:0]       LAST_X   = 32'(H - 1);
   localparam logic [31:0]       LAST_Y   = 32'(V - 1);
   localparam logic [SEL_W-1:0]  LAST_SEL = SEL_W'(N_PAT - 1);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAMES_PER_PAT - 1);

   typedef enum logic [1:0] {S_WAIT, S_RUN, S_HOLD} state_t;

   state_t                  r_state, w_state_nxt;
   logic [SEL_W-1:0]        r_sel;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_btn_q;
   logic                    r_pending;
   logic [2:0]              r_rgb;
   logic                    r_frame_end;

   logic                    w_fe;
   logic                    w_edge;
   logic                    w_req;
   logic                    w_apply;
   logic                    w_advance;
   logic                    w_cnt_inc;
   logic                    w_black;
   logic [N_PAT-1:0][2:0]   w_src;

   // Last visible pixel of the frame; unsigned 32-bit compare so
   // out-of-range positions never match.
   assign w_fe   = bus.enable && (bus.X == LAST_X) && (bus.Y == LAST_Y);
   assign w_edge = bus.btn_next & ~r_btn_q;
   // An edge landing on the fe cycle itself is honoured at that fe.
   assign w_req  = r_pending | w_edge;
   assign w_src  = bus.pat_rgb;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_WAIT;
      else        r_state <= w_state_nxt;
   end

   // Next state: WAIT syncs to the first full frame; hold is level-sampled.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_WAIT:  if (w_fe)          w_state_nxt = S_RUN;
         S_RUN:   if (bus.btn_hold)  w_state_nxt = S_HOLD;
         S_HOLD:  if (!bus.btn_hold) w_state_nxt = S_RUN;
         default:                    w_state_nxt = S_WAIT;
      endcase
   end

   // Per-state actions: advance / count on fe, black output while waiting.
   always_comb begin
      w_apply   = 1'b0;
      w_advance = 1'b0;
      w_cnt_inc = 1'b0;
      w_black   = 1'b0;
      case (r_state)
         S_WAIT: w_black = 1'b1;
         S_RUN: if (w_fe) begin
            w_apply = 1'b1;
            // Expiry and request together still advance exactly once.
            if (r_cnt == LAST_CNT || w_req) w_advance = 1'b1;
            else                            w_cnt_inc = 1'b1;
         end
         S_HOLD: if (w_fe) begin
            w_apply = 1'b1;
            if (w_req) w_advance = 1'b1;
         end
         default: w_black = 1'b1;
      endcase
   end

   // Button edge detect and the collapsed single-advance request flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_btn_q   <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         r_btn_q <= bus.btn_next;
         if (w_apply)     r_pending <= 1'b0;
         else if (w_edge) r_pending <= 1'b1;
      end
   end

   // Source index and frame counter; the counter freezes in HOLD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel <= '0;
         r_cnt <= '0;
      end else if (w_advance) begin
         r_sel <= (r_sel == LAST_SEL) ? '0 : r_sel + SEL_W'(1);
         r_cnt <= '0;
      end else if (w_cnt_inc) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Pixel path: one-clock latency, uses the selection in force before this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rgb       <= 3'b000;
         r_frame_end <= 1'b0;
      end else begin
         r_rgb       <= (bus.enable && !w_black) ? w_src[r_sel] : 3'b000;
         r_frame_end <= w_fe;
      end
   end

   assign bus.r         = r_rgb[2];
   assign bus.g         = r_rgb[1];
   assign bus.b         = r_rgb[0];
   assign bus.pat_sel   = r_sel;
   assign bus.frame_end = r_frame_end;
   assign bus.holding   = (r_state == S_HOLD);
endmodule

// File: tb/tb_pattern_scheduler.sv
// Directed bench for pattern_scheduler on a tiny 4x3 raster with blanking.
module tb_pattern_scheduler;
   localparam int H   = 4;
   localparam int V   = 3;
   localparam int NP  = 4;
   localparam int FPP = 2;
   localparam int SW  = 2;
   localparam int HT  = H + 2;
   localparam int VT  = V + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pattern_scheduler_if #(.N_PAT(NP), .SEL_W(SW)) bus ();

   pattern_scheduler #(
      .H(H), .V(V), .N_PAT(NP), .FRAMES_PER_PAT(FPP), .SEL_W(SW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;
   int hx = 0;
   int vy = 0;
   bit last_fe;
   int seq [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] rgb();
      return {bus.r, bus.g, bus.b};
   endfunction

   // One raster clock at (hx,vy); outputs are sampled 1ns after the edge.
   task automatic cyc();
      bus.X      = 32'(hx);
      bus.Y      = 32'(vy);
      bus.enable = (hx < H) && (vy < V);
      last_fe    = (hx == H - 1) && (vy == V - 1);
      @(posedge clk); #1;
      if (hx == HT - 1) begin
         hx = 0;
         vy = (vy == VT - 1) ? 0 : vy + 1;
      end else begin
         hx++;
      end
   endtask

   // Run up to and including the next last-visible pixel.
   task automatic frame(input bit nf);
      for (int i = 0; i < HT * VT; i++) begin
         if (nf && hx == H - 1 && vy == V - 1) bus.btn_next = 1'b1;
         cyc();
         if (last_fe) break;
      end
   endtask

   // Run up to and including pixel (0,0).
   task automatic to_origin();
      for (int i = 0; i < HT * VT; i++) begin
         bit org;
         org = (hx == 0) && (vy == 0);
         cyc();
         if (org) break;
      end
   endtask

   task automatic poke(input logic [31:0] x, input logic [31:0] y, input logic en);
      bus.X = x; bus.Y = y; bus.enable = en;
      @(posedge clk); #1;
   endtask

   initial begin
      int nz;
      int bad;
      bus.X = '0; bus.Y = '0; bus.enable = 1'b0;
      bus.pat_rgb = '1; bus.btn_next = 1'b0; bus.btn_hold = 1'b0;

      // Reset, then release mid-frame: black until first fe.
      repeat (HT + 2) cyc();
      chk("rst_rgb",  32'(rgb()), 0);
      chk("rst_sel",  32'(bus.pat_sel), 0);
      chk("rst_fe",   32'(bus.frame_end), 0);
      chk("rst_hold", 32'(bus.holding), 0);
      rst_n = 1'b1;
      nz = 0;
      for (int i = 0; i < HT * VT; i++) begin
         cyc();
         if (rgb() != 3'b000) nz++;
         if (last_fe) break;
      end
      chk("wait_black", nz, 0);
      chk("fe_pulse",   32'(bus.frame_end), 1);
      chk("sel_after_wait", 32'(bus.pat_sel), 0);
      cyc();
      chk("fe_1clk",    32'(bus.frame_end), 0);
      to_origin();
      chk("first_px",   32'(rgb()), 3'b111);

      // Auto advance, FRAMES_PER_PAT=2, wrap 3->0.
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("auto_seq%0d", k), 32'(bus.pat_sel), 32'(seq[k]));
         frame(1'b0);
      end
      chk("auto_seq10", 32'(bus.pat_sel), 1);

      // Three edges within one frame collapse to one advance.
      repeat (3) begin
         bus.btn_next = 1'b1; cyc();
         bus.btn_next = 1'b0; cyc();
      end
      frame(1'b0);
      chk("multi_edge", 32'(bus.pat_sel), 2);
      frame(1'b0);
      chk("cnt_restart", 32'(bus.pat_sel), 2);
      frame(1'b0);
      chk("auto_after", 32'(bus.pat_sel), 3);

      // Edge on the fe cycle at cnt=FPP-1: single advance, pending cleared.
      frame(1'b0);
      chk("cnt_last", 32'(bus.pat_sel), 3);
      frame(1'b1);
      chk("fe_edge_wrap", 32'(bus.pat_sel), 0);
      cyc(); cyc();
      bus.btn_next = 1'b0;
      frame(1'b0);
      chk("no_pending", 32'(bus.pat_sel), 0);
      frame(1'b0);
      chk("auto_resume", 32'(bus.pat_sel), 1);

      // Hold with cnt=1 frozen for 200 frames, then resume.
      frame(1'b0);
      chk("pre_hold", 32'(bus.pat_sel), 1);
      bus.btn_hold = 1'b1;
      cyc();
      chk("holding_on", 32'(bus.holding), 1);
      bad = 0;
      repeat (200) begin
         frame(1'b0);
         if (bus.pat_sel != 2'd1 || !bus.holding) bad++;
      end
      chk("hold_frozen", bad, 0);
      bus.btn_hold = 1'b0;
      cyc();
      chk("holding_off", 32'(bus.holding), 0);
      frame(1'b0);
      chk("resume_cnt", 32'(bus.pat_sel), 2);

      // Manual advance while holding.
      bus.btn_hold = 1'b1;
      cyc();
      bus.btn_next = 1'b1; cyc();
      bus.btn_next = 1'b0;
      frame(1'b0);
      chk("hold_next", 32'(bus.pat_sel), 3);
      chk("hold_still", 32'(bus.holding), 1);
      frame(1'b0);
      chk("hold_no_auto", 32'(bus.pat_sel), 3);
      bus.btn_hold = 1'b0;
      frame(1'b0);
      chk("rel_cnt0", 32'(bus.pat_sel), 3);
      frame(1'b0);
      chk("rel_adv", 32'(bus.pat_sel), 0);

      // Pixel path with distinct sources, pat_sel=2.
      repeat (4) frame(1'b0);
      chk("sel_two", 32'(bus.pat_sel), 2);
      bus.pat_rgb = {3'b001, 3'b010, 3'b100, 3'b111};
      to_origin();
      chk("pix_sel2", 32'(rgb()), 3'b010);
      poke(32'd0, 32'd0, 1'b0);
      chk("pix_blank", 32'(rgb()), 0);
      poke(32'(H + 5), 32'(V - 1), 1'b1);
      chk("oob_pix", 32'(rgb()), 3'b010);
      chk("oob_no_fe", 32'(bus.frame_end), 0);
      poke(32'(H - 1), 32'(V - 1), 1'b0);
      chk("fe_needs_en", 32'(bus.frame_end), 0);

      // Asynchronous reset mid-frame clears at once.
      poke(32'd1, 32'd1, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_sel", 32'(bus.pat_sel), 0);
      chk("async_rgb", 32'(rgb()), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
